// File: rtl/microwave_timer_ctrl.sv
// microwave_timer_ctrl: keypad-entered BCD mm:ss cooking timer with
// pause/resume, per-second duty-cycled power levels and a done beep.
// Time is held as one packed BCD string {minutes, sec_ten, sec_one} so
// keypad entry is a plain 4-bit shift and countdown is a digit-serial borrow.
module microwave_timer_ctrl #(
  parameter int MIN_DIGITS  = 1,
  parameter int CLK_DIV     = 50_000_000,
  parameter int BEEP_CYCLES = 100_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    door_closed,
  input  logic [3:0]              power_sel,
  output logic                    m_on,
  output logic [3:0]              sec_one,
  output logic [3:0]              sec_ten,
  output logic [4*MIN_DIGITS-1:0] min_bcd,
  output logic [1:0]              state,
  output logic                    done,
  output logic                    beep
);

  localparam int MW = 4 * MIN_DIGITS;
  localparam int TW = MW + 8;
  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = $clog2(BEEP_CYCLES + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_CYCLES - 1);
  localparam logic [3:0]    PWR_FULL   = 4'd10;
  localparam logic [3:0]    PHASE_LAST = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] time_q, time_d;
  logic [3:0]    pwr_q, pwr_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    phase_q, phase_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          done_q, done_d;

  logic          tick;
  logic          key_ok;
  logic [TW-1:0] time_dec;

  // Out-of-range power selections saturate to full power.
  function automatic logic [3:0] clamp_power(input logic [3:0] p);
    if ((p == 4'd0) || (p > PWR_FULL)) begin
      return PWR_FULL;
    end
    return p;
  endfunction

  // One-second BCD decrement. Digit 0 is seconds units, digit 1 seconds
  // tens (borrows to 5, so an entered 6-9 simply counts down), the rest
  // are decimal minute digits.
  function automatic logic [TW-1:0] bcd_dec(input logic [TW-1:0] t);
    logic [TW-1:0] r;
    logic          borrow;
    r      = t;
    borrow = 1'b1;
    for (int i = 0; i < MIN_DIGITS + 2; i++) begin
      if (borrow) begin
        if (r[4*i +: 4] != 4'd0) begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end else begin
          r[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
        end
      end
    end
    return r;
  endfunction

  assign tick     = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
  assign key_ok   = key_valid && (key_code <= 4'd9);
  assign time_dec = bcd_dec(time_q);

  // Next-state and datapath update; priority clear > stop > door > start > tick > key.
  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    pwr_d      = pwr_q;
    presc_d    = presc_q;
    phase_d    = phase_q;
    beep_cnt_d = beep_cnt_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          time_d = '0;
        end else if (stop) begin
          time_d = time_q;
        end else if (start) begin
          if (door_closed && (time_q != '0)) begin
            state_d = ST_RUN;
            pwr_d   = clamp_power(power_sel);
            presc_d = '0;
            phase_d = 4'd0;
          end
        end else if (key_ok) begin
          time_d = {time_q[TW-5:0], key_code};
        end
      end

      ST_RUN: begin
        if (clear) begin
          state_d = ST_IDLE;
          time_d  = '0;
        end else if (stop || !door_closed) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          presc_d = '0;
          phase_d = (phase_q == PHASE_LAST) ? 4'd0 : phase_q + 4'd1;
          time_d  = time_dec;
          if (time_dec == '0) begin
            state_d    = ST_DONE;
            beep_cnt_d = '0;
            done_d     = 1'b1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      ST_PAUSE: begin
        if (clear || stop) begin
          state_d = ST_IDLE;
          time_d  = '0;
        end else if (start && door_closed) begin
          state_d = ST_RUN;
          presc_d = '0;
          phase_d = 4'd0;
        end
      end

      ST_DONE: begin
        time_d = '0;
        if (clear || stop || start) begin
          state_d = ST_IDLE;
        end else if (beep_cnt_q == BEEP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          beep_cnt_d = beep_cnt_q + BW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register stage with synchronous reset to the idle/cleared values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      time_q     <= '0;
      pwr_q      <= PWR_FULL;
      presc_q    <= '0;
      phase_q    <= 4'd0;
      beep_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      pwr_q      <= pwr_d;
      presc_q    <= presc_d;
      phase_q    <= phase_d;
      beep_cnt_q <= beep_cnt_d;
      done_q     <= done_d;
    end
  end

  // Door is used directly so opening it kills the magnetron in the same cycle.
  assign m_on    = (state_q == ST_RUN) && door_closed && (phase_q < pwr_q);
  assign sec_one = time_q[3:0];
  assign sec_ten = time_q[7:4];
  assign min_bcd = time_q[TW-1:8];
  assign state   = state_q;
  assign done    = done_q;
  assign beep    = (state_q == ST_DONE);

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Scoreboard bench for microwave_timer_ctrl. The reference model keeps the
// cooking time as one decimal integer (entry string value) and counts
// seconds arithmetically; expectations are queued per cycle and a negedge
// monitor compares them with the DUT outputs.
module tb_microwave_timer_ctrl;

  localparam int MD = 2;
  localparam int CD = 4;
  localparam int BC = 6;
  localparam int MODV = 10000;

  logic            clk;
  logic            rst;
  logic            key_valid;
  logic [3:0]      key_code;
  logic            start;
  logic            stop;
  logic            clear;
  logic            door_closed;
  logic [3:0]      power_sel;
  logic            m_on;
  logic [3:0]      sec_one;
  logic [3:0]      sec_ten;
  logic [4*MD-1:0] min_bcd;
  logic [1:0]      state;
  logic            done;
  logic            beep;

  microwave_timer_ctrl #(
    .MIN_DIGITS (MD),
    .CLK_DIV    (CD),
    .BEEP_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .door_closed(door_closed),
    .power_sel  (power_sel),
    .m_on       (m_on),
    .sec_one    (sec_one),
    .sec_ten    (sec_ten),
    .min_bcd    (min_bcd),
    .state      (state),
    .done       (done),
    .beep       (beep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]      st;
    logic [3:0]      so;
    logic [3:0]      stn;
    logic [4*MD-1:0] mn;
    logic            mon;
    logic            dn;
    logic            bp;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: 0 idle, 1 run, 2 pause, 3 done.
  int m_st, m_e, m_pw, m_cnt, m_ticks, m_bcnt;
  bit m_done, m_known;
  bit door_r;
  logic [3:0] pwr_r;

  function automatic int dec_time(input int e);
    int s, m;
    s = e % 100;
    m = e / 100;
    if (s > 0) s = s - 1;
    else begin
      s = 59;
      m = m - 1;
    end
    return m * 100 + s;
  endfunction

  function automatic int clamp_pw(input int p);
    return (p == 0 || p > 10) ? 10 : p;
  endfunction

  function automatic exp_t expect_now(input bit door);
    exp_t x;
    int   mins;
    mins  = m_e / 100;
    x.st  = 2'(m_st);
    x.so  = 4'(m_e % 10);
    x.stn = 4'((m_e / 10) % 10);
    for (int i = 0; i < MD; i++) begin
      x.mn[4*i +: 4] = 4'(mins % 10);
      mins = mins / 10;
    end
    x.mon = (m_st == 1) && door && ((m_ticks % 10) < m_pw);
    x.dn  = m_done;
    x.bp  = (m_st == 3);
    return x;
  endfunction

  task automatic model_step(input bit r, input bit kv, input int kc, input bit st,
                            input bit sp, input bit cl, input bit door, input int pw);
    bit tk;
    m_done = 1'b0;
    if (r) begin
      m_st = 0; m_e = 0; m_pw = 10; m_cnt = 0; m_ticks = 0; m_bcnt = 0;
      m_known = 1'b1;
      return;
    end
    if (!m_known) return;
    case (m_st)
      0: begin
        if (cl) m_e = 0;
        else if (sp) begin end
        else if (st) begin
          if (door && m_e != 0) begin
            m_st = 1; m_pw = clamp_pw(pw); m_cnt = 0; m_ticks = 0;
          end
        end else if (kv && kc <= 9) m_e = (m_e * 10 + kc) % MODV;
      end
      1: begin
        tk = (m_cnt == CD - 1);
        if (cl) begin
          m_st = 0; m_e = 0;
        end else if (sp || !door) m_st = 2;
        else if (tk) begin
          m_cnt = 0;
          m_ticks++;
          m_e = dec_time(m_e);
          if (m_e == 0) begin
            m_st = 3; m_bcnt = 0; m_done = 1'b1;
          end
        end else m_cnt++;
      end
      2: begin
        if (cl || sp) begin
          m_st = 0; m_e = 0;
        end else if (st && door) begin
          m_st = 1; m_cnt = 0; m_ticks = 0;
        end
      end
      default: begin
        if (cl || sp || st) m_st = 0;
        else if (m_bcnt == BC - 1) m_st = 0;
        else m_bcnt++;
      end
    endcase
  endtask

  // One clock of stimulus: drive, queue the expectation for this cycle, step the model.
  task automatic apply(input bit r, input bit kv, input int kc, input bit st,
                       input bit sp, input bit cl);
    rst = r; key_valid = kv; key_code = 4'(kc); start = st; stop = sp; clear = cl;
    door_closed = door_r; power_sel = pwr_r;
    if (m_known) expq.push_back(expect_now(door_r));
    @(posedge clk);
    model_step(r, kv, kc, st, sp, cl, door_r, int'(pwr_r));
    #1;
  endtask

  task automatic idle();           apply(0, 0, 0, 0, 0, 0); endtask
  task automatic key(input int d); apply(0, 1, d, 0, 0, 0); endtask
  task automatic press_start();    apply(0, 0, 0, 1, 0, 0); endtask
  task automatic press_stop();     apply(0, 0, 0, 0, 1, 0); endtask
  task automatic press_clear();    apply(0, 0, 0, 0, 0, 1); endtask
  task automatic do_reset();       apply(1, 0, 0, 0, 0, 0); endtask
  task automatic idles(input int n);
    for (int i = 0; i < n; i++) idle();
  endtask

  // Advance until the next edge would deliver a one-second tick.
  task automatic to_tick_edge();
    int guard;
    guard = 0;
    while (!(m_st == 1 && m_cnt == CD - 1) && guard < 4 * CD) begin
      idle();
      guard++;
    end
    total++;
    if (!(m_st == 1 && m_cnt == CD - 1)) begin
      bad++;
      $display("FAIL tick_align: model state %0d cnt %0d, required run at cnt %0d", m_st, m_cnt, CD - 1);
    end
  endtask

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("state",   int'(state),   int'(e.st));
      chk("sec_one", int'(sec_one), int'(e.so));
      chk("sec_ten", int'(sec_ten), int'(e.stn));
      chk("min_bcd", int'(min_bcd), int'(e.mn));
      chk("m_on",    int'(m_on),    int'(e.mon));
      chk("done",    int'(done),    int'(e.dn));
      chk("beep",    int'(beep),    int'(e.bp));
    end
  end

  initial begin
    int n, r, len;
    m_known = 1'b0;
    m_st = 0; m_e = 0; m_pw = 10; m_cnt = 0; m_ticks = 0; m_bcnt = 0; m_done = 1'b0;
    door_r = 1'b1;
    pwr_r  = 4'd10;

    do_reset();
    do_reset();
    idles(2);

    // Keypad entry and top-digit discard.
    key(1); key(3); key(0); idle();
    key(4); key(5); key(6); key(7); key(8); key(12); idle();
    press_clear();

    // 0:03 at full power, through done and the beep window.
    key(3); pwr_r = 4'd10; press_start();
    idles(12 + BC + 3);

    // 0:20 at power 3: duty pattern over two full phase cycles.
    key(2); key(0); pwr_r = 4'd3; press_start();
    pwr_r = 4'd10;
    idles(20 * CD + 4);

    // Door opened mid-run, then resumed with the latched power.
    key(1); key(0); pwr_r = 4'd5; press_start();
    pwr_r = 4'd1;
    idles(6);
    door_r = 1'b0; idles(4);
    press_start();
    door_r = 1'b1; idle();
    press_start(); idles(3 * CD);
    press_clear();

    // Start refused on zero time or open door.
    press_start(); idle();
    key(5); door_r = 1'b0; press_start(); idle();
    door_r = 1'b1; press_clear();

    // 1:00 -> 0:59, then clear and stop together.
    key(1); key(0); key(0); press_start(); idles(CD + 2);
    apply(0, 0, 0, 0, 1, 1); idle();

    // 0:99 -> 0:98, then reset mid-run.
    key(9); key(9); pwr_r = 4'd0; press_start(); idles(CD + 2);
    do_reset(); idles(2);

    // Stop coincident with a tick: no decrement.
    key(7); pwr_r = 4'd10; press_start(); to_tick_edge(); press_stop(); idle();
    press_start(); to_tick_edge(); idle(); press_clear();

    // Door opening on the final tick: pause with time kept.
    key(1); press_start(); to_tick_edge();
    door_r = 1'b0; idle(); idles(2);
    door_r = 1'b1; press_start(); idles(CD + BC + 2);

    // Randomized episodes.
    for (int ep = 0; ep < 40; ep++) begin
      door_r = 1'b1;
      press_clear();
      n = $urandom_range(1, 2);
      for (int k = 0; k < n; k++) key($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) key($urandom_range(10, 15));
      pwr_r = 4'($urandom_range(0, 15));
      press_start();
      len = $urandom_range(20, 200);
      for (int c = 0; c < len; c++) begin
        r = $urandom_range(0, 99);
        if (r < 3) press_stop();
        else if (r < 5) begin
          door_r = ~door_r;
          idle();
        end
        else if (r < 6) press_clear();
        else if (r < 10) key($urandom_range(0, 15));
        else if (r < 16 && m_st != 1) press_start();
        else if (r < 19) begin
          pwr_r = 4'($urandom_range(0, 15));
          idle();
        end
        else if (r == 19 && $urandom_range(0, 9) == 0) do_reset();
        else if (r == 20 && m_st != 1) apply(0, 1, $urandom_range(0, 9), 1, 0, 0);
        else idle();
      end
    end

    @(negedge clk);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, required 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/microwave_timer_ctrl.md
# microwave_timer_ctrl

Parametrised next-generation microwave cooking controller: a single-clock block that takes keypad digit entry, counts down a BCD mm:ss cooking time, and drives the magnetron with selectable power (duty-cycled per second). It adds pause/resume, power levels, a configurable minutes-digit count and a done beep. It sits between the synchronised, debounced front-panel inputs and the 7-segment decoders, which consume its BCD outputs.

## Interface
- MIN_DIGITS, 1: number of BCD minute digits (≥1); maximum entry 10^MIN_DIGITS−1 minutes, 99 seconds.
- CLK_DIV, 50_000_000: clock cycles per one-second tick (≥2).
- BEEP_CYCLES, 100_000_000: cycles `beep` stays high in DONE (≥1).
- clk  in  1  system clock; everything sampled on rising edge.
- rst  in  1  reset, synchronous, active-high.
- key_valid  in  1  one-cycle strobe; key_code valid.
- key_code  in  4  0–9 digit; 10–15 ignored.
- start  in  1  one-cycle start/resume request, active-high.
- stop  in  1  one-cycle pause/cancel request, active-high.
- clear  in  1  one-cycle clear request, active-high.
- door_closed  in  1  level; 1 = door closed.
- power_sel  in  4  power level 1–10; 0 or >10 treated as 10.
- m_on  out  1  magnetron enable.
- sec_one  out  4  BCD seconds units.
- sec_ten  out  4  BCD seconds tens.
- min_bcd  out  4*MIN_DIGITS  BCD minutes, least significant digit in [3:0].
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
- done  out  1  one-cycle pulse on entry to DONE.
- beep  out  1  high while in DONE.

## Operation
- Reset: state=IDLE, all time digits 0, power latch=10, prescaler=0, phase=0, m_on=0, done=0, beep=0.
- Per-cycle input priority: clear > stop > door_closed=0 > start > tick > key_valid.
- IDLE: valid digit key shifts the time string left one digit: new digit→sec_one, sec_one→sec_ten, sec_ten→min_bcd[3:0], each minute digit up one; top minute digit discarded. clear zeroes time. start with door_closed=1 and time≠0 → RUN, latches power_sel (clamped); otherwise start ignored.
- RUN: keys ignored. On tick, decrement time by one second: sec_one 0→9 with borrow; sec_ten 0→5 with borrow; minutes decimal borrow across digits. Entered sec_ten values 6–9 are legal (0:99 = 99 s) and count down normally. Decrement reaching all-zero → DONE. stop or door_closed=0 → PAUSE, time held. clear → IDLE, time zeroed.
- PAUSE: time and power latch held. start with door_closed=1 → RUN (power not re-latched). stop or clear → IDLE, time zeroed. Keys ignored.
- DONE: time reads 0. beep high; after BEEP_CYCLES cycles → IDLE. clear, stop, or start → IDLE immediately.
- Power duty: phase counter 0–9 advances on each tick in RUN, wraps 9→0. m_on = (state==RUN) & door_closed & (phase < power latch); power 10 = continuous, power 1 = 1 s of every 10 s.

## Timing
- State, time, power latch, prescaler, phase are registers; m_on is combinational from them and door_closed, so opening the door drops m_on in the same cycle (zero latency).
- Prescaler and phase reset to 0 on every entry to RUN; tick fires when prescaler==CLK_DIV−1 in RUN only. First decrement occurs CLK_DIV cycles after the cycle start is sampled.
- State, digit, and done changes are visible the cycle after the causing input is sampled.
- Simultaneous stop and tick: no decrement. Tick that would reach zero with door open same cycle: PAUSE, time unchanged.
- rst mid-RUN: next cycle returns to the reset values above; m_on=0.

## Test plan
- Reset, keys 1,3,0 (MIN_DIGITS=1) → min=1, sec_ten=3, sec_one=0; keys 4,5,6,7 → display 5:67, digit 4 discarded.
- Enter 0:03, power_sel=10, start, CLK_DIV=4 → m_on high continuously, display decrements every 4 cycles; after 12 cycles state=DONE, done one-cycle pulse, beep for BEEP_CYCLES, then IDLE.
- Enter 0:20, power_sel=3, CLK_DIV=2 → m_on high for ticks with phase 0–2, low for phase 3–9, pattern repeats every 10 ticks.
- Running at 0:10, drop door_closed → m_on low the same cycle, state=PAUSE, time frozen; close door, start → RUN resumes from 0:10 with the same power.
- start with time 0:00 or door open → remains IDLE, m_on=0; 1:00 decrements to 0:59; 0:99 → 0:98.
- clear and stop asserted together in RUN → IDLE, time 0:00; rst asserted mid-RUN → all outputs at reset values next cycle.
